tlb_op_sequencer: RTL and testbench

Sequences the CP0 TLB-management instructions (TLBWI, TLBWR, TLBP, TLBR) against the 16-entry TLB. It sits between the pipeline/CP0 and the TLB. It owns the MIPS Random register, and drives the TLB write and probe strobes. It also writes probe and read results back into CP0 Index and EntryHi/EntryLo0/EntryLo1/PageMask. The pipeline stalls on `op_ready` until `done`.

---
 rtl/mmu_pkg.sv | 40 ++++
 rtl/tlb_random_counter.sv | 34 +++
 rtl/tlb_op_sequencer.sv | 139 +++++++++++++
 tb/tb_tlb_op_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU definitions: TLB op codes, sequencer state encoding, probe result
// layout and TLB entry field offsets used by the TLB, CP0 and the op sequencer.
// Pure declarations; no logic, no latency, no flow control.
package mmu_pkg;

  // CP0 TLB instruction codes presented on op_code
  localparam logic [1:0] OP_TLBWI = 2'b00;
  localparam logic [1:0] OP_TLBWR = 2'b01;
  localparam logic [1:0] OP_TLBP  = 2'b10;
  localparam logic [1:0] OP_TLBR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_PROBE     = 3'd2,
    ST_PROBE_CAP = 3'd3,
    ST_READ      = 3'd4,
    ST_READ_CAP  = 3'd5
  } state_t;

  // Probe result: bit 31 set on miss, low bits carry the matching index
  localparam int PROBE_MISS_BIT = 31;

  // TLB entry layout: {ASID, G, VPN2, PFN1/D1/V1, PFN0/D0/V0}
  localparam int ENTRY_W        = 80;
  localparam int ENTRY_ASID_LSB = 72;
  localparam int ENTRY_G_BIT    = 71;
  localparam int ENTRY_VPN2_LSB = 52;
  localparam int ENTRY_LO1_LSB  = 26;
  localparam int ENTRY_LO0_LSB  = 0;

  typedef struct packed {
    logic [7:0]  asid;
    logic        g;
    logic [18:0] vpn2;
    logic [25:0] lo1;
    logic [25:0] lo0;
  } entry_t;

endpackage

// File: rtl/tlb_random_counter.sv
// MIPS Random register: free-running down-counter over [wired, NUM_ENTRIES-1].
// Latency: new value every cycle; a Wired write reloads the top on the next edge.
// Backpressure: none, runs unconditionally.
// Ports: clk, rst_n (async low); wired/wired_we from CP0; random to CP0 and the sequencer.
module tlb_random_counter
  import mmu_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_ENTRIES - 1);

  // Reload when reaching Wired (or below it, after Wired was raised) so the
  // wired entries are never selected by TLBWR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random <= TOP;
    end else if (wired_we) begin
      random <= TOP;
    end else if (random <= wired) begin
      random <= TOP;
    end else begin
      random <= random - 1'b1;
    end
  end

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBWI/TLBWR/TLBP/TLBR against the TLB and writes results back to CP0.
// Latency: writes finish 1 cycle after accept, probe/read 2 cycles after accept.
// Backpressure: op_ready high only in IDLE; op_valid while busy is ignored, no queueing.
// Ports: op_valid/op_code/op_ready/done to the pipeline; cp0_* and index_/entry_ write-back
// to CP0; tlb_we/tlb_widx/tlb_probe/probe_result/tlb_ridx/tlb_rdata to the TLB.
module tlb_op_sequencer
  import mmu_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [1:0]         op_code,
  output logic               op_ready,
  output logic               done,
  input  logic [IDX_W-1:0]   cp0_index,
  input  logic [IDX_W-1:0]   cp0_wired,
  input  logic               cp0_wired_we,
  output logic [IDX_W-1:0]   random,
  output logic               tlb_we,
  output logic [IDX_W-1:0]   tlb_widx,
  output logic               tlb_probe,
  input  logic [31:0]        probe_result,
  output logic               index_we,
  output logic [31:0]        index_wdata,
  output logic [IDX_W-1:0]   tlb_ridx,
  input  logic [ENTRY_W-1:0] tlb_rdata,
  output logic               entry_we,
  output logic [ENTRY_W-1:0] entry_wdata
);

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      idx_wdata_q;
  entry_t           entry_q;

  tlb_random_counter #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_random (
    .clk      (clk),
    .rst_n    (rst_n),
    .wired    (cp0_wired),
    .wired_we (cp0_wired_we),
    .random   (random)
  );

  // Index and capture registers drive the outputs directly; strobes are
  // qualified by their own registered enables, so no input reaches an output
  // combinationally.
  assign tlb_widx    = idx_q;
  assign tlb_ridx    = idx_q;
  assign index_wdata = idx_wdata_q;
  assign entry_wdata = entry_q;

  // Strobes are registered one state ahead: they are set on the edge that
  // enters the state in which they must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_ready    <= 1'b1;
      done        <= 1'b0;
      tlb_we      <= 1'b0;
      tlb_probe   <= 1'b0;
      index_we    <= 1'b0;
      entry_we    <= 1'b0;
      idx_q       <= '0;
      idx_wdata_q <= '0;
      entry_q     <= '0;
    end else begin
      done      <= 1'b0;
      tlb_we    <= 1'b0;
      tlb_probe <= 1'b0;
      index_we  <= 1'b0;
      entry_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_ready <= 1'b0;
            case (op_code)
              OP_TLBWI: begin
                idx_q  <= cp0_index;
                tlb_we <= 1'b1;
                done   <= 1'b1;
                state  <= ST_WRITE;
              end
              OP_TLBWR: begin
                // Pre-update Random: a Wired write this cycle only affects the counter
                idx_q  <= random;
                tlb_we <= 1'b1;
                done   <= 1'b1;
                state  <= ST_WRITE;
              end
              OP_TLBP: begin
                tlb_probe <= 1'b1;
                state     <= ST_PROBE;
              end
              OP_TLBR: begin
                idx_q <= cp0_index;
                state <= ST_READ;
              end
            endcase
          end
        end
        ST_WRITE: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_PROBE: begin
          idx_wdata_q <= probe_result;
          index_we    <= 1'b1;
          done        <= 1'b1;
          state       <= ST_PROBE_CAP;
        end
        ST_PROBE_CAP: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_READ: begin
          entry_q  <= tlb_rdata;
          entry_we <= 1'b1;
          done     <= 1'b1;
          state    <= ST_READ_CAP;
        end
        ST_READ_CAP: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer: Random counter, each TLB op, back-to-back
// ordering and reset abort. Small TLB entry table answers tlb_ridx reads.
module tb_tlb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic        done;
  logic [3:0]  cp0_index;
  logic [3:0]  cp0_wired;
  logic        cp0_wired_we;
  logic [3:0]  random;
  logic        tlb_we;
  logic [3:0]  tlb_widx;
  logic        tlb_probe;
  logic [31:0] probe_result;
  logic        index_we;
  logic [31:0] index_wdata;
  logic [3:0]  tlb_ridx;
  logic [79:0] tlb_rdata;
  logic        entry_we;
  logic [79:0] entry_wdata;

  logic [79:0] tlb_mem [16];
  logic [5:0]  flg;
  int          checks = 0;
  int          errors = 0;
  int          found;

  // {tlb_we, tlb_probe, index_we, entry_we, done, op_ready}
  localparam logic [5:0] F_IDLE  = 6'b000001;
  localparam logic [5:0] F_WR    = 6'b100010;
  localparam logic [5:0] F_PROBE = 6'b010000;
  localparam logic [5:0] F_PCAP  = 6'b001010;
  localparam logic [5:0] F_READ  = 6'b000000;
  localparam logic [5:0] F_RCAP  = 6'b000110;

  always #5 clk = ~clk;

  assign flg       = {tlb_we, tlb_probe, index_we, entry_we, done, op_ready};
  assign tlb_rdata = tlb_mem[tlb_ridx];

  tlb_op_sequencer #(.NUM_ENTRIES(16), .IDX_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_ready     (op_ready),
    .done         (done),
    .cp0_index    (cp0_index),
    .cp0_wired    (cp0_wired),
    .cp0_wired_we (cp0_wired_we),
    .random       (random),
    .tlb_we       (tlb_we),
    .tlb_widx     (tlb_widx),
    .tlb_probe    (tlb_probe),
    .probe_result (probe_result),
    .index_we     (index_we),
    .index_wdata  (index_wdata),
    .tlb_ridx     (tlb_ridx),
    .tlb_rdata    (tlb_rdata),
    .entry_we     (entry_we),
    .entry_wdata  (entry_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++)
      tlb_mem[i] = {8'hA0 | 8'(i), 1'b1, 19'h40000 | 19'(i),
                    26'h1555555 ^ 26'(i << 4), 26'h0AAAAAA ^ 26'(i)};

    rst_n        = 1'b0;
    op_valid     = 1'b0;
    op_code      = 2'b00;
    cp0_index    = 4'd0;
    cp0_wired    = 4'd0;
    cp0_wired_we = 1'b0;
    probe_result = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_flags", 80'(flg), 80'(F_IDLE));
    chk("rst_random", 80'(random), 80'(15));
    chk("rst_widx", 80'(tlb_widx), 80'(0));
    chk("rst_ridx", 80'(tlb_ridx), 80'(0));
    chk("rst_index_wdata", 80'(index_wdata), 80'(0));
    chk("rst_entry_wdata", entry_wdata, 80'(0));

    // Random after release, Wired=0: 15,14,...,0,15
    rst_n = 1'b1;
    chk("rand_start", 80'(random), 80'(15));
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("rand_dec_%0d", i), 80'(random), 80'(15 - i));
    end
    tick();
    chk("rand_wrap0", 80'(random), 80'(15));

    // Wired=12: 14,13,12,15, then Wired write at 13 reloads 15
    cp0_wired = 4'd12;
    tick(); chk("wired_14", 80'(random), 80'(14));
    tick(); chk("wired_13", 80'(random), 80'(13));
    tick(); chk("wired_12", 80'(random), 80'(12));
    tick(); chk("wired_wrap", 80'(random), 80'(15));
    tick();
    tick(); chk("wired_pre_we", 80'(random), 80'(13));
    cp0_wired_we = 1'b1;
    tick(); chk("wired_we_reload", 80'(random), 80'(15));
    cp0_wired_we = 1'b0;
    tick(); chk("wired_after_we", 80'(random), 80'(14));

    // TLBWI index 5
    cp0_index = 4'd5;
    op_code   = 2'b00;
    op_valid  = 1'b1;
    tick();
    op_valid  = 1'b0;
    cp0_index = 4'd0;
    chk("wi_flags_t1", 80'(flg), 80'(F_WR));
    chk("wi_widx", 80'(tlb_widx), 80'(5));
    tick();
    chk("wi_flags_t2", 80'(flg), 80'(F_IDLE));

    // TLBWR with Random=9
    cp0_wired = 4'd0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (random == 4'd9) found = 1;
      else tick();
    end
    chk("wait_rand9", 80'(found), 80'(1));
    op_code  = 2'b01;
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("wr_flags", 80'(flg), 80'(F_WR));
    chk("wr_widx9", 80'(tlb_widx), 80'(9));
    tick();
    chk("wr_idle", 80'(flg), 80'(F_IDLE));

    // TLBWR at Random=7 with a simultaneous Wired write
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (random == 4'd7) found = 1;
      else tick();
    end
    chk("wait_rand7", 80'(found), 80'(1));
    op_valid     = 1'b1;
    cp0_wired_we = 1'b1;
    tick();
    cp0_wired_we = 1'b0;
    chk("wr_we_widx7", 80'(tlb_widx), 80'(7));
    chk("wr_we_rand15", 80'(random), 80'(15));
    chk("wr_we_flags", 80'(flg), 80'(F_WR));

    // Back-to-back TLBWR, TLBP, TLBR with op_valid held throughout
    tick();
    chk("b2b_ready", 80'(flg), 80'(F_IDLE));
    chk("b2b_rand14", 80'(random), 80'(14));
    tick();
    chk("b2b_wr_flags", 80'(flg), 80'(F_WR));
    chk("b2b_wr_widx", 80'(tlb_widx), 80'(14));
    op_code      = 2'b10;
    probe_result = 32'h0000_0007;
    tick();
    chk("b2b_idle1", 80'(flg), 80'(F_IDLE));
    tick();
    chk("b2b_probe", 80'(flg), 80'(F_PROBE));
    op_code   = 2'b11;
    cp0_index = 4'd3;
    tick();
    chk("b2b_pcap", 80'(flg), 80'(F_PCAP));
    chk("b2b_hit_wdata", 80'(index_wdata), 80'(32'h0000_0007));
    tick();
    chk("b2b_idle2", 80'(flg), 80'(F_IDLE));
    tick();
    op_valid = 1'b0;
    chk("b2b_read", 80'(flg), 80'(F_READ));
    chk("b2b_ridx", 80'(tlb_ridx), 80'(3));
    tick();
    chk("b2b_rcap", 80'(flg), 80'(F_RCAP));
    chk("b2b_entry3", entry_wdata, tlb_mem[3]);
    tick();
    chk("b2b_idle3", 80'(flg), 80'(F_IDLE));

    // TLBP miss
    op_code      = 2'b10;
    probe_result = 32'h8000_0000;
    op_valid     = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("miss_probe", 80'(flg), 80'(F_PROBE));
    tick();
    chk("miss_pcap", 80'(flg), 80'(F_PCAP));
    chk("miss_wdata", 80'(index_wdata), 80'(32'h8000_0000));
    tick();
    chk("miss_idle", 80'(flg), 80'(F_IDLE));

    // TLBR index 10; index latched at accept
    op_code   = 2'b11;
    cp0_index = 4'd10;
    op_valid  = 1'b1;
    tick();
    op_valid  = 1'b0;
    cp0_index = 4'd0;
    chk("rd10_ridx", 80'(tlb_ridx), 80'(10));
    chk("rd10_read", 80'(flg), 80'(F_READ));
    tick();
    chk("rd10_rcap", 80'(flg), 80'(F_RCAP));
    chk("rd10_entry", entry_wdata, tlb_mem[10]);
    tick();

    // TLBR index 3 aborted by reset in T+1
    cp0_index = 4'd3;
    op_valid  = 1'b1;
    tick();
    op_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("abort_flags", 80'(flg), 80'(F_IDLE));
    chk("abort_entry_wdata", entry_wdata, 80'(0));
    chk("abort_ridx", 80'(tlb_ridx), 80'(0));
    chk("abort_random", 80'(random), 80'(15));
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_post_flags", 80'(flg), 80'(F_IDLE));
    chk("abort_post_entry", entry_wdata, 80'(0));
    chk("abort_post_random", 80'(random), 80'(14));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
